// File: rtl/dsp_pkg.sv
// Shared definitions for the audio moving-average filter.
//   filter_state_t : FSM encoding (CLEAR while history is being zeroed, RUN otherwise)
//   depth_of()     : window depth from its log2, never smaller than 2
//   AUDIO_W/CH     : default sample width and channel count of the codec path
package dsp_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } filter_state_t;

    localparam int AUDIO_W  = 24;
    localparam int AUDIO_CH = 2;

    function automatic int depth_of(input int log2_n);
        return (log2_n < 1) ? 2 : (1 << log2_n);
    endfunction

endpackage

// File: rtl/moving_average_filter_if.sv
// Sample-stream bundle between the codec path and the moving-average filter.
//   mode      : 1 = filtered output, 0 = raw sample (sampled with the accepted set)
//   clear     : request to zero all filter history
//   in_valid  / in_ready / in_data  : input sample set, channel c at [c*W +: W]
//   out_valid / out_data            : one-cycle pulse per result, same packing
// Handshake: a sample set is transferred on a rising clock edge where
// in_valid and in_ready are both 1; in_ready may depend combinationally on
// clear. There is no output back-pressure: out_valid is a single-cycle pulse
// and out_data holds its value between pulses.
interface moving_average_filter_if #(
    parameter int W        = dsp_pkg::AUDIO_W,
    parameter int CHANNELS = dsp_pkg::AUDIO_CH
) ();

    logic                  mode;
    logic                  clear;
    logic                  in_valid;
    logic                  in_ready;
    logic [CHANNELS*W-1:0] in_data;
    logic                  out_valid;
    logic [CHANNELS*W-1:0] out_data;

    modport master (
        output mode, clear, in_valid, in_data,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  mode, clear, in_valid, in_data,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/ma_channel.sv
// One channel of the boxcar filter: DEPTH x W history ring, running sum and
// output register.
//   clk, reset : clock, asynchronous active-low reset
//   wr_en      : accept x into slot ptr and update the running sum
//   clr_en     : zero slot ptr and the running sum (takes priority over wr_en)
//   ptr        : ring slot addressed this cycle
//   x          : incoming sample (two's complement)
//   mode       : 1 = rounded average, 0 = raw x
//   y          : registered output, holds between writes
module ma_channel #(
    parameter int W      = 24,
    parameter int LOG2_N = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              clr_en,
    input  logic [LOG2_N-1:0] ptr,
    input  logic [W-1:0]      x,
    input  logic              mode,
    output logic [W-1:0]      y
);
    import dsp_pkg::*;

    localparam int DEPTH = depth_of(LOG2_N);
    localparam int AW    = W + LOG2_N;

    logic [W-1:0]         hist_q [DEPTH];
    logic [W-1:0]         hist_wdata;
    logic                 hist_we;
    logic [W-1:0]         old_sample;
    logic signed [AW-1:0] x_ext;
    logic signed [AW-1:0] old_ext;
    logic signed [AW-1:0] acc_q, acc_d, acc_new;
    logic [W-1:0]         avg;
    logic [W-1:0]         y_q, y_d;

    assign old_sample = hist_q[ptr];
    assign x_ext      = {{LOG2_N{x[W-1]}}, x};
    assign old_ext    = {{LOG2_N{old_sample[W-1]}}, old_sample};
    assign acc_new    = acc_q + x_ext - old_ext;

    // (acc + DEPTH/2) >>> LOG2_N equals floor(acc / DEPTH) plus one exactly
    // when the discarded fraction is at least one half, i.e. when bit
    // LOG2_N-1 is set. The high slice is exactly W bits wide, and the +1 can
    // only happen when the floor is below the positive maximum.
    assign avg = acc_new[AW-1:LOG2_N] + W'(acc_new[LOG2_N-1]);

    always_comb begin
        hist_we    = 1'b0;
        hist_wdata = x;
        acc_d      = acc_q;
        y_d        = y_q;
        if (clr_en) begin
            hist_we    = 1'b1;
            hist_wdata = '0;
            acc_d      = '0;
        end else if (wr_en) begin
            hist_we = 1'b1;
            acc_d   = acc_new;
            y_d     = mode ? avg : x;
        end
    end

    // History needs no reset: the FSM always sweeps it to zero before RUN.
    always_ff @(posedge clk) begin
        if (hist_we) begin
            hist_q[ptr] <= hist_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
            y_q   <= '0;
        end else begin
            acc_q <= acc_d;
            y_q   <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: rtl/moving_average_filter.sv
// Multi-channel moving-average (boxcar) filter over the last 2^LOG2_N samples,
// full-precision running sum, single rounding at the output, bypass mode and
// a history clear that sweeps every slot to zero.
//   clk       : system clock
//   reset     : asynchronous active-low reset
//   bus       : sample stream (mode, clear, in_*, out_*), slave side
//   dbg_state : current FSM state
module moving_average_filter #(
    parameter int W        = dsp_pkg::AUDIO_W,
    parameter int LOG2_N   = 3,
    parameter int CHANNELS = dsp_pkg::AUDIO_CH
) (
    input  logic                   clk,
    input  logic                   reset,
    moving_average_filter_if.slave bus,
    output dsp_pkg::filter_state_t dbg_state
);
    import dsp_pkg::*;

    localparam int DEPTH = depth_of(LOG2_N);

    filter_state_t         state_q, state_d;
    logic [LOG2_N-1:0]     cnt_q, cnt_d;
    logic [LOG2_N-1:0]     ptr_q, ptr_d;
    logic [LOG2_N-1:0]     ch_ptr;
    logic                  out_valid_q, out_valid_d;
    logic                  in_ready;
    logic                  accept;
    logic                  clr_en;
    logic [CHANNELS*W-1:0] out_data_w;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        ch_ptr      = ptr_q;
        in_ready    = 1'b0;
        accept      = 1'b0;
        clr_en      = 1'b0;
        unique case (state_q)
            CLEAR: begin
                // The sweep counter addresses the ring while clearing.
                clr_en = 1'b1;
                ch_ptr = cnt_q;
                if (bus.clear) begin
                    cnt_d = '0;
                end else if (cnt_q == LOG2_N'(DEPTH - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    ptr_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                in_ready = ~bus.clear;
                accept   = bus.in_valid & in_ready;
                if (bus.clear) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else if (accept) begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: state_d = CLEAR;
        endcase
        out_valid_d = accept;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= CLEAR;
            cnt_q       <= '0;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        ma_channel #(
            .W      (W),
            .LOG2_N (LOG2_N)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .wr_en  (accept),
            .clr_en (clr_en),
            .ptr    (ch_ptr),
            .x      (bus.in_data[c*W +: W]),
            .mode   (bus.mode),
            .y      (out_data_w[c*W +: W])
        );
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_w;
    assign dbg_state     = state_q;

endmodule
